rr_mux4: RTL and testbench

Four-input stream multiplexer with round-robin arbitration, packet locking and a registered output. It is the gathering end of the 1:4 demultiplexing path: four independent valid/ready sources are merged onto one output stream. `out_sel` carries the 2-bit source index so that a downstream 1:4 demux can route each beat back by that select value.

---
 rtl/rr_mux4.sv | 143 ++++++++++++++
 tb/tb_rr_mux4.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// rr_mux4: four-input valid/ready stream gather with round-robin arbitration,
// packet locking and a registered output stage. out_sel tags every beat with
// the index of the source channel so a downstream demux can route it back.
module rr_mux4 #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    input  logic [3:0]     in_last,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_sel,
    output logic           out_last,
    input  logic           out_ready
);

    typedef enum logic [0:0] {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } state_e;

    state_e         state_q;
    logic [1:0]     ptr_q;
    logic [1:0]     gnt_q;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic [1:0]     out_sel_q;
    logic           out_last_q;

    logic           load;
    logic           picked;
    logic [1:0]     pick;
    logic [1:0]     cand;
    logic           xfer;
    logic [W-1:0]   sel_data;
    logic           sel_last;

    // The output register can take a beat when empty or being drained.
    assign load = !out_valid_q || out_ready;
    // picked already implies in_valid[pick], so load && picked is a transfer.
    assign xfer = load && picked;

    // Arbitration: locked channel only, otherwise first valid from ptr upward.
    always_comb begin
        picked = 1'b0;
        pick   = ptr_q;
        cand   = ptr_q;
        if (state_q == StLocked) begin
            // An idle locked source blocks everyone else until its last beat.
            picked = in_valid[gnt_q];
            pick   = gnt_q;
        end else begin
            // Scan from the farthest offset down so the nearest valid wins.
            for (int i = 3; i >= 0; i--) begin
                cand = ptr_q + 2'(i);
                if (in_valid[cand]) begin
                    picked = 1'b1;
                    pick   = cand;
                end
            end
        end
    end

    // Select the picked channel's data and end-of-packet flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (pick == 2'(k)) begin
                sel_data = in_data[k*W +: W];
                sel_last = in_last[k];
            end
        end
    end

    // One-hot accept towards the picked source; silenced during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && xfer) begin
            in_ready[pick] = 1'b1;
        end
    end

    // Arbiter FSM plus registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StUnlocked;
            ptr_q       <= 2'd0;
            gnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            if (load) begin
                // Without a transfer the payload holds; only valid drops.
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= sel_data;
                    out_sel_q  <= pick;
                    out_last_q <= sel_last;
                end
            end
            if (xfer) begin
                unique case (state_q)
                    StUnlocked: begin
                        if (sel_last) begin
                            // Single-beat packet: stay unlocked, move fairness on.
                            ptr_q <= pick + 2'd1;
                        end else begin
                            state_q <= StLocked;
                            gnt_q   <= pick;
                        end
                    end
                    StLocked: begin
                        if (sel_last) begin
                            state_q <= StUnlocked;
                            ptr_q   <= gnt_q + 2'd1;
                        end
                    end
                    default: state_q <= StUnlocked;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

    // At most one source is ever accepted.
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

    // A stalled output beat stays put until the consumer takes it.
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)
                                       && $stable(out_last)));

endmodule

// File: tb/tb_rr_mux4.sv
// Bench for rr_mux4: a rule-level model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_rr_mux4;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     in_valid = 4'b0;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_last = 4'b0;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_last;
    logic           out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    rr_mux4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_ptr = 0;
    bit         m_locked = 1'b0;
    int         m_gnt = 0;
    bit         m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    int         m_os = 0;
    bit         m_ol = 1'b0;

    // Which source the rules allow this cycle, or -1 for none.
    function automatic int model_pick();
        if (m_locked) return in_valid[m_gnt] ? m_gnt : -1;
        for (int i = 0; i < 4; i++) begin
            if (in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int p;
        p = model_pick();
        if (rst || p < 0 || !(!m_ov || out_ready)) return 4'b0000;
        return 4'b0001 << p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr <= 0; m_locked <= 1'b0; m_gnt <= 0;
            m_ov <= 1'b0; m_od <= '0; m_os <= 0; m_ol <= 1'b0;
        end else if (!m_ov || out_ready) begin
            if (model_pick() >= 0) begin
                m_ov <= 1'b1;
                m_od <= in_data[model_pick()*W +: W];
                m_os <= model_pick();
                m_ol <= in_last[model_pick()];
                if (in_last[model_pick()]) begin
                    m_locked <= 1'b0;
                    m_ptr    <= (model_pick() + 1) % 4;
                end else begin
                    m_locked <= 1'b1;
                    m_gnt    <= model_pick();
                end
            end else begin
                m_ov <= 1'b0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        check("m_in_ready", {28'd0, in_ready}, {28'd0, model_ready()});
        check("m_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("m_out_data", {24'd0, out_data}, {24'd0, m_od});
        check("m_out_sel", {30'd0, out_sel}, m_os);
        check("m_out_last", {31'd0, out_last}, {31'd0, m_ol});
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ch(input int k, input bit v, input logic [W-1:0] d, input bit l);
        in_valid[k] = v;
        in_data[k*W +: W] = d;
        in_last[k] = l;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input bit v, input logic [W-1:0] d,
                           input logic [1:0] s);
        check({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            check({name, "_data"}, {24'd0, out_data}, {24'd0, d});
            check({name, "_sel"}, {30'd0, out_sel}, {30'd0, s});
        end
    endtask

    initial begin
        // Reset with all channels valid; data 10+k, single-beat packets.
        for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 8'(8'h10 + k), 1'b1);
        step(); step();
        check("rst_ready", {28'd0, in_ready}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'h0);
        #2 rst = 1'b0;
        #1 check("first_grant", {28'd0, in_ready}, 32'h1);

        // Round-robin fairness: 0,1,2,3,0,1,... every cycle.
        for (int n = 0; n < 8; n++) begin
            step();
            chk_out("rr", 1'b1, 8'(8'h10 + (n % 4)), 2'(n % 4));
        end

        // Asynchronous reset mid-cycle with everything valid.
        #2 rst = 1'b1;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'h0);
        check("async_data", {24'd0, out_data}, 32'h0);
        check("async_sel", {30'd0, out_sel}, 32'h0);
        check("async_ready", {28'd0, in_ready}, 32'h0);
        step();
        in_valid = 4'b0;
        #2 rst = 1'b0;

        // Move ptr to 2 with a single beat from channel 1.
        step();
        set_ch(1, 1'b1, 8'h11, 1'b1);
        step();
        set_ch(1, 1'b0, 8'h00, 1'b0);
        chk_out("pre_lock", 1'b1, 8'h11, 2'd1);

        // Packet lock: channel 2 sends A1,A2,A3 while 0 and 3 stay valid.
        set_ch(0, 1'b1, 8'h0C, 1'b1);
        set_ch(3, 1'b1, 8'h33, 1'b1);
        set_ch(2, 1'b1, 8'hA1, 1'b0);
        step(); chk_out("lock_a1", 1'b1, 8'hA1, 2'd2);
        set_ch(2, 1'b1, 8'hA2, 1'b0);
        step(); chk_out("lock_a2", 1'b1, 8'hA2, 2'd2);
        set_ch(2, 1'b1, 8'hA3, 1'b1);
        step(); chk_out("lock_a3", 1'b1, 8'hA3, 2'd2);
        check("lock_a3_last", {31'd0, out_last}, 32'h1);
        set_ch(2, 1'b0, 8'h00, 1'b0);
        step(); chk_out("after_lock_ch3", 1'b1, 8'h33, 2'd3);
        set_ch(3, 1'b0, 8'h00, 1'b0);
        step(); chk_out("after_lock_ch0", 1'b1, 8'h0C, 2'd0);

        // Lock with gap: ptr is 1, channel 1 locks, then idles 3 cycles.
        set_ch(1, 1'b1, 8'hB1, 1'b0);
        step(); chk_out("gap_b1", 1'b1, 8'hB1, 2'd1);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 3; n++) begin
            #1 check("gap_ready0", {31'd0, in_ready[0]}, 32'h0);
            step(); chk_out("gap_idle", 1'b0, 8'h00, 2'd0);
        end
        set_ch(1, 1'b1, 8'hB2, 1'b1);
        step(); chk_out("gap_b2", 1'b1, 8'hB2, 2'd1);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        step(); chk_out("gap_ch0", 1'b1, 8'h0C, 2'd0);
        set_ch(0, 1'b0, 8'h00, 1'b0);
        step(); chk_out("bp_idle", 1'b0, 8'h00, 2'd0);

        // Backpressure: 5A from channel 3 held 4 cycles.
        out_ready = 1'b0;
        set_ch(3, 1'b1, 8'h5A, 1'b1);
        step(); chk_out("bp_load", 1'b1, 8'h5A, 2'd3);
        set_ch(3, 1'b1, 8'h5B, 1'b1);
        for (int n = 0; n < 4; n++) begin
            #1 check("bp_ready", {28'd0, in_ready}, 32'h0);
            step(); chk_out("bp_hold", 1'b1, 8'h5A, 2'd3);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", {28'd0, in_ready}, 32'h8);
        step(); chk_out("bp_next", 1'b1, 8'h5B, 2'd3);

        // Idle and wrap: ptr wrapped to 0, only channel 0 valid.
        set_ch(3, 1'b0, 8'h00, 1'b0);
        set_ch(0, 1'b1, 8'h0D, 1'b1);
        #1 check("wrap_ready", {28'd0, in_ready}, 32'h1);
        step(); chk_out("wrap_ch0", 1'b1, 8'h0D, 2'd0);
        set_ch(0, 1'b0, 8'h00, 1'b0);
        step(); chk_out("wrap_idle", 1'b0, 8'h00, 2'd0);
        check("wrap_idle_hold", {24'd0, out_data}, 32'h0D);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
